// File: rtl/md_scheduler_if.sv
// Handshake/bus bundle between the E-stage control and the HI/LO multiply/divide scheduler.
// The master drives requests and reads results; the slave is the scheduler.
interface md_scheduler_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hilo_sel;
  logic        md_use_d;
  logic        busy;
  logic        stall_d;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b, hilo_sel, md_use_d,
    input  busy, stall_d, hilo_out, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, hilo_sel, md_use_d,
    output busy, stall_d, hilo_out, hi, lo
  );
endinterface

// File: rtl/md_scheduler.sv
// Fixed-latency multiply/divide sequencer owning HI/LO. Results are computed at issue
// and held in pending registers until the busy window expires.
//
// state | meaning
// IDLE  | no op in flight; accepts MD ops, MTHI/MTLO write directly
// MUL   | multiply in flight, counting down MULT_CYCLES
// DIV   | divide in flight, counting down DIV_CYCLES
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_scheduler_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;

  logic [63:0] prod_s, prod_u;
  logic [32:0] div_a_s, div_b_s, quo_s, rem_s;
  logic [31:0] div_b_safe, quo_u, rem_u;
  logic        div_zero;

  // Arithmetic is evaluated on the operands present at the issue edge only.
  always_comb begin
    prod_s     = $signed({{32{bus.src_a[31]}}, bus.src_a}) *
                 $signed({{32{bus.src_b[31]}}, bus.src_b});
    prod_u     = {32'd0, bus.src_a} * {32'd0, bus.src_b};
    div_zero   = (bus.src_b == 32'd0);
    div_b_safe = div_zero ? 32'd1 : bus.src_b;
    // 33-bit signed keeps 0x80000000 / -1 well defined (wraps to 0x80000000, rem 0).
    div_a_s    = {bus.src_a[31], bus.src_a};
    div_b_s    = {div_b_safe[31], div_b_safe};
    quo_s      = $signed(div_a_s) / $signed(div_b_s);
    rem_s      = $signed(div_a_s) % $signed(div_b_s);
    quo_u      = bus.src_a / div_b_safe;
    rem_u      = bus.src_a % div_b_safe;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              OP_MULT, OP_MULTU: begin
                pend_hi <= (bus.md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                pend_lo <= (bus.md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                pend_wr <= 1'b1;
                cnt     <= CW'(MULT_CYCLES - 1);
                state   <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi <= (bus.md_op == OP_DIV) ? rem_s[31:0] : rem_u;
                pend_lo <= (bus.md_op == OP_DIV) ? quo_s[31:0] : quo_u;
                pend_wr <= !div_zero;
                cnt     <= CW'(DIV_CYCLES - 1);
                state   <= DIV;
              end
              OP_MTHI: hi_q <= bus.src_a;
              OP_MTLO: lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (cnt == '0) begin
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.stall_d  = bus.md_use_d & (bus.busy | (bus.start & (bus.md_op <= OP_DIVU)));
  assign bus.hilo_out = bus.hilo_sel ? lo_q : hi_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed cases followed by randomized ops
// compared against a 64-bit arithmetic reference model of HI/LO.
module tb_md_scheduler;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi, m_lo;

  md_scheduler_if bus ();

  md_scheduler #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what HI/LO become after the op completes, and whether it is a timed op.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl, output int n);
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    nh = m_hi; nl = m_lo; n = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: begin p = 64'(sa * sb); nh = p[63:32]; nl = p[31:0]; n = MULT_CYCLES; end
      4'd2: begin p = 64'(a) * 64'(b); nh = p[63:32]; nl = p[31:0]; n = MULT_CYCLES; end
      4'd1: begin
        n = DIV_CYCLES;
        if (b != 0) begin q = sa / sb; r = sa % sb; qv = 64'(q); rv = 64'(r);
          nl = qv[31:0]; nh = rv[31:0]; end
      end
      4'd3: begin
        n = DIV_CYCLES;
        if (b != 0) begin nl = a / b; nh = a % b; end
      end
      4'd4: nh = a;
      4'd5: nl = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d);
    logic [31:0] nh, nl;
    int n;
    model(op, a, b, nh, nl, n);
    bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b; bus.md_use_d = use_d;
    #1;
    chk("stall_issue", 32'(bus.stall_d), 32'(use_d & (n > 0)));
    step();
    bus.start = 1'b0; bus.md_op = 4'hF;
    bus.src_a = $urandom; bus.src_b = $urandom;
    #1;
    for (int i = 0; i < n; i++) begin
      chk("busy_window", 32'(bus.busy), 32'd1);
      chk("stall_busy", 32'(bus.stall_d), 32'(use_d));
      if (i < n - 1) chk("hi_hold", bus.hi, m_hi);
      step();
    end
    m_hi = nh; m_lo = nl;
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("stall_done", 32'(bus.stall_d), 32'd0);
    chk("hi_result", bus.hi, m_hi);
    chk("lo_result", bus.lo, m_lo);
    bus.hilo_sel = 1'($urandom_range(0, 1));
    #1;
    chk("hilo_out", bus.hilo_out, bus.hilo_sel ? m_lo : m_hi);
    bus.md_use_d = 1'b0;
  endtask

  initial begin
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [31:0] a, b;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15, 4'd9};
    reset = 1'b1;
    bus.start = 1'b0; bus.md_op = 4'hF; bus.src_a = '0; bus.src_b = '0;
    bus.hilo_sel = 1'b0; bus.md_use_d = 1'b0;
    m_hi = '0; m_lo = '0;
    step(); step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall_d), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_hilo_out", bus.hilo_out, 32'd0);
    reset = 1'b0;

    run_op(4'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", bus.lo, 32'hFFFF_FFF1);
    bus.hilo_sel = 1'b0; #1;
    chk("mfhi_read", bus.hilo_out, 32'hFFFF_FFFF);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi_const", bus.hi, 32'h0000_0001);
    chk("multu_lo_const", bus.lo, 32'hFFFF_FFFE);
    run_op(4'd3, 32'd7, 32'd2, 1'b0);
    chk("divu_lo_const", bus.lo, 32'd3);
    chk("divu_hi_const", bus.hi, 32'd1);
    run_op(4'd1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    run_op(4'd1, 32'd5, 32'd0, 1'b1);
    chk("div0_hi_kept", bus.hi, 32'hFFFF_FFFF);
    chk("div0_lo_kept", bus.lo, 32'hFFFF_FFFD);
    run_op(4'd5, 32'h1234_5678, 32'd0, 1'b1);
    chk("mtlo_const", bus.lo, 32'h1234_5678);

    // DIV request held through the whole MUL window, including the commit edge.
    bus.start = 1'b1; bus.md_op = 4'd0; bus.src_a = 32'd3; bus.src_b = 32'd4;
    step();
    bus.md_op = 4'd1; bus.src_a = 32'd100; bus.src_b = 32'd7;
    for (int i = 0; i < MULT_CYCLES; i++) begin
      #1 chk("busy_ignore_start", 32'(bus.busy), 32'd1);
      step();
    end
    bus.start = 1'b0; bus.md_op = 4'hF;
    #1;
    chk("ign_busy_done", 32'(bus.busy), 32'd0);
    chk("ign_lo", bus.lo, 32'd12);
    chk("ign_hi", bus.hi, 32'd0);
    step();
    chk("ign_no_restart", 32'(bus.busy), 32'd0);
    m_hi = 32'd0; m_lo = 32'd12;

    // Reset during busy cycle 3 of a divide.
    bus.start = 1'b1; bus.md_op = 4'd1; bus.src_a = 32'd100; bus.src_b = 32'd7;
    step();
    bus.start = 1'b0; bus.md_op = 4'hF;
    step(); step();
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    m_hi = '0; m_lo = '0;
    run_op(4'd0, 32'd2, 32'd3, 1'b0);
    chk("post_rst_lo", bus.lo, 32'd6);
    chk("post_rst_hi", bus.hi, 32'd0);

    for (int k = 0; k < 30; k++) begin
      op = ops[$urandom_range(0, 7)];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      run_op(op, a, b, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
